bus_arbiter_4: RTL and testbench
================================

Name: bus_arbiter_4

Overview:
Round-robin arbiter and sequencer for the shared 16-bit bus that is fed by the 4:1 source multiplexer. It takes requests from four sources (A..D) and grants the bus to one source at a time. Its select output drives the multiplexer's 2-bit control, and it registers the selected word onto the bus output. Each grant lasts at most MAX_BURST transfers, so no source can starve the others.

Parameters:
DATA_W, 16, width of each source word and of p_Output
MAX_BURST, 4, maximum transfers per grant (>=1)

Ports:
p_Clock  in  1  clock; all state updates on rising edge
p_Reset  in  1  synchronous reset, active-high
p_Req  in  4  request per source; bit0=A, bit1=B, bit2=C, bit3=D
p_A  in  DATA_W  source A word
p_B  in  DATA_W  source B word
p_C  in  DATA_W  source C word
p_D  in  DATA_W  source D word
p_Grant  out  4  one-hot grant, registered; 0 when idle
p_Control  out  2  index of granted source (00=A..11=D), registered; drives mux control
p_Output  out  DATA_W  registered bus word
p_Valid  out  1  high for one cycle per transfer captured into p_Output
p_Busy  out  1  high while in state GRANT

Behaviour:
- Reset (p_Reset=1 at an edge; it overrides everything, including mid-burst):
  - state=IDLE, p_Grant=0, p_Control=0, p_Output=0, p_Valid=0.
  - Priority pointer ptr=0; transfer counter cnt=0.
- Arbitration function: scan p_Req starting at index ptr, in the order ptr, ptr+1, … mod 4. The first set bit wins.
- IDLE, at each edge:
  - If p_Req!=0: go to GRANT; p_Grant=onehot(win), p_Control=win, cnt=0.
  - Grant latency is 1 cycle from the edge at which the request is sampled.
  - If p_Req==0: stay in IDLE; p_Control holds its last value.
- GRANT with index g, at each edge:
  - Transfer (p_Req[g]=1): p_Output<=selected word (A/B/C/D by g); p_Valid<=1; cnt<=cnt+1.
  - No transfer (p_Req[g]=0): p_Valid<=0; p_Output holds.
  - Release condition: p_Req[g]=0, or a transfer occurs with cnt==MAX_BURST-1.
  - On release: ptr<=(g+1) mod 4, then re-arbitrate at the same edge using the new ptr on the current p_Req.
    - If there is a winner: grant it directly, with no idle cycle, and cnt<=0.
    - If there is no winner: go to IDLE with p_Grant=0.
  - If burst expired and p_Req[g] is still high: g is lowest priority, so it is re-granted only if no other request is present (continuous grant, cnt restarts).
- Requests from non-granted sources are ignored until release. Request bits may change freely in any cycle.
- p_Valid is 0 in any cycle that did not follow a transfer edge, including IDLE.
- p_Busy = (state==GRANT).
- Counter width: clog2(MAX_BURST+1); it never exceeds MAX_BURST-1 at a sampling edge.
- The data path adds no width conversion; the word is copied as-is.

Test Plan:
1. Reset while active: p_Reset=1 for 2 edges with p_Req=4'b1111 -> p_Grant=0, p_Control=0, p_Output=0, p_Valid=0, p_Busy=0. The first grant after deassert goes to A (0001).
2. Single requester: p_Req=4'b0100, p_C=16'hBEEF held.
   - One edge later: p_Grant=0100, p_Control=10.
   - From the next edge: p_Output=16'hBEEF, p_Valid=1.
   - After 4 transfers: continuous re-grant to C, p_Grant never drops, p_Valid stays 1.
3. Full contention, MAX_BURST=4: p_Req=4'b1111 held, with p_A..p_D=16'h000A/000B/000C/000D.
   - p_Grant must follow 0001, 0010, 0100, 1000, 0001…, each held 4 cycles with no gap.
   - p_Output shows each source's value 4 times in turn.
4. Early release: A granted; drop p_Req[0] after 2 transfers while p_Req[3]=1.
   - At the edge where the drop is seen: p_Grant=1000, p_Control=11.
   - p_Valid=0 for exactly one cycle, then p_Output=16'h000D.
5. Rotation fairness: after A's burst ends (ptr=1), apply p_Req=4'b0011 -> B granted before A.
6. Reset mid-burst: assert p_Reset during C's second transfer.
   - Next edge: all outputs 0 and ptr=0.
   - Deassert with p_Req=4'b1001 -> A granted first.

Source files
------------

// File: rtl/bus_arbiter_4.sv
// Round-robin arbiter and sequencer for the shared 4-source bus.
// Grants one source at a time for at most MAX_BURST transfers.
module bus_arbiter_4 #(
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 4
) (
    input  logic              p_Clock,
    input  logic              p_Reset,
    input  logic [3:0]        p_Req,
    input  logic [DATA_W-1:0] p_A,
    input  logic [DATA_W-1:0] p_B,
    input  logic [DATA_W-1:0] p_C,
    input  logic [DATA_W-1:0] p_D,
    output logic [3:0]        p_Grant,
    output logic [1:0]        p_Control,
    output logic [DATA_W-1:0] p_Output,
    output logic              p_Valid,
    output logic              p_Busy
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] LAST = CW'(MAX_BURST - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t            state, state_n;
    logic [3:0]        grant_n;
    logic [1:0]        ctrl_n;
    logic [DATA_W-1:0] out_n;
    logic              valid_n;
    logic [1:0]        ptr, ptr_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [DATA_W-1:0] word;
    logic [2:0]        win_idle, win_rel;
    logic              xfer;

    // Result is {found, index}; the scan runs backwards so the
    // lowest offset from the pointer is written last and wins.
    function automatic logic [2:0] arb(input logic [3:0] req,
                                       input logic [1:0] p);
        logic [2:0] r;
        logic [1:0] idx;
        r = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            idx = p + 2'(i);
            if (req[idx]) r = {1'b1, idx};
        end
        return r;
    endfunction

    assign win_idle = arb(p_Req, ptr);
    assign win_rel  = arb(p_Req, p_Control + 2'd1);
    assign p_Busy   = (state == GRANT);

    always_comb begin
        word = p_A;
        unique case (p_Control)
            2'd0: word = p_A;
            2'd1: word = p_B;
            2'd2: word = p_C;
            2'd3: word = p_D;
        endcase
    end

    always_comb begin
        state_n = state;
        grant_n = p_Grant;
        ctrl_n  = p_Control;
        out_n   = p_Output;
        valid_n = 1'b0;
        ptr_n   = ptr;
        cnt_n   = cnt;
        xfer    = 1'b0;
        unique case (state)
            IDLE: begin
                if (win_idle[2]) begin
                    state_n = GRANT;
                    grant_n = 4'd1 << win_idle[1:0];
                    ctrl_n  = win_idle[1:0];
                    cnt_n   = '0;
                end
            end
            GRANT: begin
                xfer = p_Req[p_Control];
                if (xfer) begin
                    out_n   = word;
                    valid_n = 1'b1;
                    cnt_n   = cnt + 1'b1;
                end
                // Release on a dropped request or on the last burst beat.
                if (!xfer || cnt == LAST) begin
                    ptr_n = p_Control + 2'd1;
                    if (win_rel[2]) begin
                        grant_n = 4'd1 << win_rel[1:0];
                        ctrl_n  = win_rel[1:0];
                        cnt_n   = '0;
                    end else begin
                        state_n = IDLE;
                        grant_n = 4'd0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge p_Clock) begin
        if (p_Reset) begin
            state     <= IDLE;
            p_Grant   <= 4'd0;
            p_Control <= 2'd0;
            p_Output  <= '0;
            p_Valid   <= 1'b0;
            ptr       <= 2'd0;
            cnt       <= '0;
        end else begin
            state     <= state_n;
            p_Grant   <= grant_n;
            p_Control <= ctrl_n;
            p_Output  <= out_n;
            p_Valid   <= valid_n;
            ptr       <= ptr_n;
            cnt       <= cnt_n;
        end
    end

endmodule

// File: tb/tb_bus_arbiter_4.sv
// Directed bench for bus_arbiter_4 with an expectation queue
// filled at each drive step and drained after the clock edge.
module tb_bus_arbiter_4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] a, b, c, d;
    logic [3:0]  grant;
    logic [1:0]  ctrl;
    logic [15:0] out;
    logic        valid;
    logic        busy;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [3:0]  grant;
        logic [1:0]  ctrl;
        logic [15:0] out;
        logic        valid;
        logic        busy;
    } exp_t;

    exp_t q[$];

    bus_arbiter_4 #(.DATA_W(16), .MAX_BURST(4)) dut (
        .p_Clock  (clk),
        .p_Reset  (rst),
        .p_Req    (req),
        .p_A      (a),
        .p_B      (b),
        .p_C      (c),
        .p_D      (d),
        .p_Grant  (grant),
        .p_Control(ctrl),
        .p_Output (out),
        .p_Valid  (valid),
        .p_Busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic step(input string tag, input logic r,
                        input logic [3:0] rq, input logic [3:0] eg,
                        input logic [1:0] ec, input logic [15:0] eo,
                        input logic ev, input logic eb);
        exp_t e;
        rst = r;
        req = rq;
        q.push_back('{eg, ec, eo, ev, eb});
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk({tag, ".grant"}, 32'(grant), 32'(e.grant));
        chk({tag, ".ctrl"},  32'(ctrl),  32'(e.ctrl));
        chk({tag, ".out"},   32'(out),   32'(e.out));
        chk({tag, ".valid"}, 32'(valid), 32'(e.valid));
        chk({tag, ".busy"},  32'(busy),  32'(e.busy));
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b1111;
        a = 16'h000A;
        b = 16'h000B;
        c = 16'h000C;
        d = 16'h000D;
        #2;

        step("rst0", 1, 4'b1111, 4'b0000, 2'd0, 16'h0, 0, 0);
        step("rst1", 1, 4'b1111, 4'b0000, 2'd0, 16'h0, 0, 0);

        step("g0", 0, 4'b1111, 4'b0001, 2'd0, 16'h0, 0, 1);
        for (int k = 1; k <= 16; k++) begin
            step($sformatf("rr%0d", k), 0, 4'b1111,
                 4'd1 << ((k / 4) % 4), 2'((k / 4) % 4),
                 16'h000A + 16'((k - 1) / 4), 1, 1);
        end

        step("er0", 0, 4'b1001, 4'b0001, 2'd0, 16'h000A, 1, 1);
        step("er1", 0, 4'b1001, 4'b0001, 2'd0, 16'h000A, 1, 1);
        step("er2", 0, 4'b1000, 4'b1000, 2'd3, 16'h000A, 0, 1);
        step("er3", 0, 4'b1000, 4'b1000, 2'd3, 16'h000D, 1, 1);

        step("idl", 0, 4'b0000, 4'b0000, 2'd3, 16'h000D, 0, 0);
        step("fa0", 0, 4'b0001, 4'b0001, 2'd0, 16'h000D, 0, 1);
        step("fa1", 0, 4'b0001, 4'b0001, 2'd0, 16'h000A, 1, 1);
        step("fa2", 0, 4'b0000, 4'b0000, 2'd0, 16'h000A, 0, 0);
        step("fb0", 0, 4'b0011, 4'b0010, 2'd1, 16'h000A, 0, 1);
        step("fb1", 0, 4'b0011, 4'b0010, 2'd1, 16'h000B, 1, 1);

        step("mc0", 0, 4'b0100, 4'b0100, 2'd2, 16'h000B, 0, 1);
        step("mc1", 0, 4'b0100, 4'b0100, 2'd2, 16'h000C, 1, 1);
        step("mrs", 1, 4'b0100, 4'b0000, 2'd0, 16'h0, 0, 0);
        step("mg0", 0, 4'b1001, 4'b0001, 2'd0, 16'h0, 0, 1);
        step("mg1", 0, 4'b1001, 4'b0001, 2'd0, 16'h000A, 1, 1);

        c = 16'hBEEF;
        step("srs", 1, 4'b0100, 4'b0000, 2'd0, 16'h0, 0, 0);
        step("sg0", 0, 4'b0100, 4'b0100, 2'd2, 16'h0, 0, 1);
        for (int k = 1; k <= 8; k++) begin
            step($sformatf("sc%0d", k), 0, 4'b0100,
                 4'b0100, 2'd2, 16'hBEEF, 1, 1);
        end

        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
